// File: rtl/frames_in.sv
// ---------------------------------------------------------------------------
// frames_in -- synthesizable video frame source.
//
// Generates VGA-style timing (vga_vs / vga_hs / vga_de) and 24-bit RGB pixels
// read from a double-buffered on-chip frame store. A host fills the back bank
// through the write port and requests a swap. The swap takes effect at the
// next frame start.
//
// Line layout : H_BLANK blank clocks, then H_ACT active pixels.
// Frame layout: V_ACT active lines, then V_BLANK blank lines.
//
// Ports
//   vga_clk       pixel clock
//   vga_rst_n     asynchronous active-low reset
//   enable        run request (level); a running frame always completes
//   wr_en         frame store write strobe (targets the back bank)
//   wr_addr       pixel address, row*H_ACT+col
//   wr_data       RGB pixel {R,G,B}
//   swap_req      pulse: back bank complete, swap at next frame start
//   pat_en        test pattern select (used only with TEST_PATTERN_EN)
//   swap_pending  swap requested, not yet applied
//   vga_vs        high during active lines
//   vga_hs        line sync, high for the first HS_W clocks of each line
//   vga_de        pixel valid
//   vga_data      pixel RGB, 0 whenever vga_de is 0
//   frame_cnt     frames started, mod 256
//
// Build option
//   TEST_PATTERN_EN  when defined, pat_en (sampled at each frame start)
//                    replaces store data with {col, row, frame_cnt}.
//
// All timing outputs and vga_data come out 2 clocks after the counter
// position that produced them. Stage 1 covers the synchronous store read.
// Stage 2 covers the output register.
// ---------------------------------------------------------------------------
module frames_in #(
    parameter int H_ACT   = 16,
    parameter int V_ACT   = 16,
    parameter int H_BLANK = 8,
    parameter int V_BLANK = 4,
    parameter int HS_W    = 2
) (
    input  logic                           vga_clk,
    input  logic                           vga_rst_n,
    input  logic                           enable,
    input  logic                           wr_en,
    input  logic [$clog2(H_ACT*V_ACT)-1:0] wr_addr,
    input  logic [23:0]                    wr_data,
    input  logic                           swap_req,
    input  logic                           pat_en,
    output logic                           swap_pending,
    output logic                           vga_vs,
    output logic                           vga_hs,
    output logic                           vga_de,
    output logic [23:0]                    vga_data,
    output logic [7:0]                     frame_cnt
);

    localparam int H_TOT = H_BLANK + H_ACT;
    localparam int V_TOT = V_ACT + V_BLANK;
    localparam int N_PIX = H_ACT * V_ACT;
    localparam int AW    = $clog2(N_PIX);
    localparam int HW    = $clog2(H_TOT);
    localparam int VW    = $clog2(V_TOT);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t          state_reg, state_next;
    logic [HW-1:0]   h_reg, h_next;
    logic [VW-1:0]   v_reg, v_next;
    logic            front_reg;
    logic            front_d1_reg;
    logic            pend_reg;
    logic [7:0]      fcnt_reg;

    logic            vs_d1_reg, hs_d1_reg, de_d1_reg;
    logic            vs_reg, hs_reg, de_reg;
    logic [23:0]     data_reg;

    logic            in_run;
    logic            h_last, v_last;
    logic            frame_start;
    logic            vs_c, hs_c, de_c;
    logic [AW-1:0]   rd_addr;
    logic [23:0]     rd_bank [2];
    logic [23:0]     pix_d1;

    assign in_run      = (state_reg == RUN);
    assign h_last      = (h_reg == HW'(H_TOT - 1));
    assign v_last      = (v_reg == VW'(V_TOT - 1));
    assign frame_start = in_run && (h_reg == '0) && (v_reg == '0);

    // Timing decoded from the raw counter position; gated by RUN so the
    // counters parked at 0 in IDLE do not produce an hsync pulse.
    assign vs_c = in_run && (v_reg < VW'(V_ACT));
    assign hs_c = in_run && (h_reg < HW'(HS_W));
    assign de_c = vs_c && (h_reg >= HW'(H_BLANK));

    // Modular arithmetic in AW bits is exact for every active position. Blank
    // positions may produce any address; that data is masked by de.
    assign rd_addr = AW'(v_reg) * AW'(H_ACT) + AW'(h_reg) - AW'(H_BLANK);

    // ------------------------------------------------------------------
    // FSM: next state and counter update
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        h_next     = h_reg;
        v_next     = v_reg;
        case (state_reg)
            IDLE: begin
                h_next = '0;
                v_next = '0;
                if (enable) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (h_last) begin
                    h_next = '0;
                    if (v_last) begin
                        // Only the last clock of a frame may return to IDLE,
                        // so a frame is never truncated.
                        v_next = '0;
                        if (!enable) begin
                            state_next = IDLE;
                        end
                    end else begin
                        v_next = v_reg + 1'b1;
                    end
                end else begin
                    h_next = h_reg + 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                h_next     = '0;
                v_next     = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Frame store: one inferred RAM per bank, both read every cycle; the
    // bank that was front at read time is selected one clock later.
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < 2; gi++) begin : g_bank
        logic [23:0] mem [N_PIX];
        logic [23:0] q_reg;

        always_ff @(posedge vga_clk) begin
            if (wr_en && (front_reg != 1'(gi))) begin
                mem[wr_addr] <= wr_data;
            end
            q_reg <= mem[rd_addr];
        end

        assign rd_bank[gi] = q_reg;
    end

`ifdef TEST_PATTERN_EN
    logic        pat_reg;
    logic [23:0] pat_d1_reg;

    always_ff @(posedge vga_clk or negedge vga_rst_n) begin
        if (!vga_rst_n) begin
            pat_reg    <= 1'b0;
            pat_d1_reg <= '0;
        end else begin
            if (frame_start) begin
                pat_reg <= pat_en;
            end
            // fcnt_reg already holds this frame's count once active pixels
            // are reached, because it updates at the frame start.
            pat_d1_reg <= {8'(h_reg - HW'(H_BLANK)), 8'(v_reg), fcnt_reg};
        end
    end

    assign pix_d1 = pat_reg ? pat_d1_reg : rd_bank[front_d1_reg];
`else
    logic unused_pat_en;
    assign unused_pat_en = pat_en;
    assign pix_d1        = rd_bank[front_d1_reg];
`endif

    // ------------------------------------------------------------------
    // State, swap control, frame counter and output pipeline
    // ------------------------------------------------------------------
    always_ff @(posedge vga_clk or negedge vga_rst_n) begin
        if (!vga_rst_n) begin
            state_reg    <= IDLE;
            h_reg        <= '0;
            v_reg        <= '0;
            front_reg    <= 1'b0;
            front_d1_reg <= 1'b0;
            pend_reg     <= 1'b0;
            fcnt_reg     <= '0;
            vs_d1_reg    <= 1'b0;
            hs_d1_reg    <= 1'b0;
            de_d1_reg    <= 1'b0;
            vs_reg       <= 1'b0;
            hs_reg       <= 1'b0;
            de_reg       <= 1'b0;
            data_reg     <= '0;
        end else begin
            state_reg <= state_next;
            h_reg     <= h_next;
            v_reg     <= v_next;

            // A request arriving on the frame-start cycle itself is only
            // recorded here; it is applied at the following frame start.
            if (frame_start && pend_reg) begin
                pend_reg  <= 1'b0;
                front_reg <= ~front_reg;
            end else if (swap_req) begin
                pend_reg <= 1'b1;
            end

            if (frame_start) begin
                fcnt_reg <= fcnt_reg + 8'd1;
            end

            vs_d1_reg    <= vs_c;
            hs_d1_reg    <= hs_c;
            de_d1_reg    <= de_c;
            front_d1_reg <= front_reg;

            vs_reg   <= vs_d1_reg;
            hs_reg   <= hs_d1_reg;
            de_reg   <= de_d1_reg;
            data_reg <= de_d1_reg ? pix_d1 : 24'd0;
        end
    end

    assign swap_pending = pend_reg;
    assign vga_vs       = vs_reg;
    assign vga_hs       = hs_reg;
    assign vga_de       = de_reg;
    assign vga_data     = data_reg;
    assign frame_cnt    = fcnt_reg;

endmodule

// File: tb/tb_frames_in.sv
// ---------------------------------------------------------------------------
// tb_frames_in -- directed self-checking bench for frames_in.
// Main DUT uses the default geometry (24 clocks/line, 480 clocks/frame).
// A second, tiny instance (8 clocks/frame) is used for the frame_cnt wrap.
// Inputs are driven on the falling edge and outputs are sampled there too.
// ---------------------------------------------------------------------------
module tb_frames_in;

    localparam int K_PLAIN = 0;   // data = addr
    localparam int K_A     = 1;   // first bank-1 image
    localparam int K_B     = 2;   // second bank-1 image
    localparam int K_PAT   = 3;   // test pattern {col,row,frame_cnt}

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        enable = 1'b0;
    logic        wr_en = 1'b0;
    logic [7:0]  wr_addr = '0;
    logic [23:0] wr_data = '0;
    logic        swap_req = 1'b0;
    logic        pat_en = 1'b0;
    logic        swap_pending, vga_vs, vga_hs, vga_de;
    logic [23:0] vga_data;
    logic [7:0]  frame_cnt;

    logic        s_rst_n = 1'b1;
    logic        s_en = 1'b0;
    logic        s_wr_en = 1'b0;
    logic [0:0]  s_wr_addr = '0;
    logic [23:0] s_wr_data = '0;
    logic        s_swap_req = 1'b0;
    logic        s_pat_en = 1'b0;
    logic        s_pend, s_vs, s_hs, s_de;
    logic [23:0] s_data;
    logic [7:0]  s_fcnt;

    int n_vec = 0;
    int n_bad = 0;

    // per-frame statistics filled by collect()
    int          st_wait, st_vs_hi, st_de, st_lines, st_first_de, st_leak;
    logic        st_hs0, st_pend;
    logic [7:0]  st_fc0;
    logic [23:0] pix [256];

    always #5 clk = ~clk;

    frames_in u_dut (
        .vga_clk      (clk),
        .vga_rst_n    (rst_n),
        .enable       (enable),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .swap_req     (swap_req),
        .pat_en       (pat_en),
        .swap_pending (swap_pending),
        .vga_vs       (vga_vs),
        .vga_hs       (vga_hs),
        .vga_de       (vga_de),
        .vga_data     (vga_data),
        .frame_cnt    (frame_cnt)
    );

    frames_in #(
        .H_ACT(2), .V_ACT(1), .H_BLANK(2), .V_BLANK(1), .HS_W(1)
    ) u_small (
        .vga_clk      (clk),
        .vga_rst_n    (s_rst_n),
        .enable       (s_en),
        .wr_en        (s_wr_en),
        .wr_addr      (s_wr_addr),
        .wr_data      (s_wr_data),
        .swap_req     (s_swap_req),
        .pat_en       (s_pat_en),
        .swap_pending (s_pend),
        .vga_vs       (s_vs),
        .vga_hs       (s_hs),
        .vga_de       (s_de),
        .vga_data     (s_data),
        .frame_cnt    (s_fcnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [23:0] exp_pix(input int kind, input int i, input logic [7:0] fc);
        logic [7:0] a;
        logic [7:0] col;
        logic [7:0] row;
        a   = 8'(i);
        col = 8'(i % 16);
        row = 8'(i / 16);
        case (kind)
            K_A:     return {a, ~a, 8'h11};
            K_B:     return {8'hC3, a, 8'h3C};
            K_PAT:   return {col, row, fc};
            default: return {16'h0, a};
        endcase
    endfunction

    // Waits for a vs rising edge; n = falling edges waited.
    task automatic wait_vs_rise(output int n);
        logic last;
        logic found;
        last  = vga_vs;
        found = 1'b0;
        n     = 0;
        while (!found && n < 2000) begin
            @(negedge clk);
            n++;
            if (vga_vs && !last) found = 1'b1;
            last = vga_vs;
        end
        chk("vs_rise_seen", 32'(found), 32'd1);
    endtask

    task automatic collect();
        int   w;
        int   npix;
        logic prev_de;
        wait_vs_rise(w);
        st_wait = w;
        st_vs_hi = 0; st_de = 0; st_lines = 0; st_first_de = -1; st_leak = 0;
        npix = 0;
        prev_de = 1'b0;
        for (int i = 0; i < 480; i++) begin
            if (i > 0) @(negedge clk);
            if (i == 0) begin
                st_hs0 = vga_hs;
                st_fc0 = frame_cnt;
            end
            if (i == 400) st_pend = swap_pending;
            if (vga_vs) st_vs_hi++;
            if (vga_de) begin
                st_de++;
                if (st_first_de < 0) st_first_de = i;
                if (!prev_de) st_lines++;
                if (npix < 256) pix[npix] = vga_data;
                npix++;
            end else if (vga_data != 24'd0) begin
                st_leak++;
            end
            prev_de = vga_de;
        end
    endtask

    task automatic verify(input string tag, input int kind, input int fc,
                          input int wait_exp, input int pend_exp);
        int          nbad;
        int          first;
        logic [23:0] e;
        logic [23:0] e_first;
        chk({tag, "_wait"},    32'(st_wait),     32'(wait_exp));
        chk({tag, "_vs_hi"},   32'(st_vs_hi),    32'd384);
        chk({tag, "_de_cnt"},  32'(st_de),       32'd256);
        chk({tag, "_lines"},   32'(st_lines),    32'd16);
        chk({tag, "_first_de"},32'(st_first_de), 32'd8);
        chk({tag, "_hs0"},     32'(st_hs0),      32'd1);
        chk({tag, "_leak"},    32'(st_leak),     32'd0);
        chk({tag, "_fc"},      32'(st_fc0),      32'(fc));
        chk({tag, "_pend400"}, 32'(st_pend),     32'(pend_exp));
        nbad  = 0;
        first = -1;
        e_first = '0;
        for (int i = 0; i < 256; i++) begin
            e = exp_pix(kind, i, 8'(fc));
            if (pix[i] !== e) begin
                nbad++;
                if (first < 0) begin
                    first   = i;
                    e_first = e;
                end
            end
        end
        chk({tag, "_pix_bad"}, 32'(nbad), 32'd0);
        if (first >= 0) chk({tag, "_pix_first"}, 32'(pix[first]), 32'(e_first));
        $display("frame %s: fc=%0d vs_hi=%0d de=%0d first_de=%0d bad_pix=%0d",
                 tag, st_fc0, st_vs_hi, st_de, st_first_de, nbad);
    endtask

    initial begin
        int w;
        int quiet;
        int s_vs_n, s_hs_n, s_de_n;

        // ---------------- reset state ----------------
        #1 rst_n = 1'b0;
        s_rst_n = 1'b0;
        #2;
        chk("rst_vs",   32'(vga_vs),       32'd0);
        chk("rst_hs",   32'(vga_hs),       32'd0);
        chk("rst_de",   32'(vga_de),       32'd0);
        chk("rst_data", 32'(vga_data),     32'd0);
        chk("rst_fc",   32'(frame_cnt),    32'd0);
        chk("rst_pend", 32'(swap_pending), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // ---------------- fill bank 1 with image A, request swap ----------
        for (int a = 0; a < 256; a++) begin
            @(negedge clk);
            wr_en = 1'b1; wr_addr = 8'(a); wr_data = exp_pix(K_A, a, 8'd0);
        end
        @(negedge clk);
        wr_en = 1'b0; swap_req = 1'b1;
        @(negedge clk);
        swap_req = 1'b0;
        chk("idle_pend_set", 32'(swap_pending), 32'd1);
        chk("idle_vs",       32'(vga_vs),       32'd0);
        chk("idle_hs",       32'(vga_hs),       32'd0);
        enable = 1'b1;

        // ---------------- frame 1 shows A; bank 0 written meanwhile -------
        fork
            collect();
            begin
                repeat (10) @(negedge clk);
                for (int a = 0; a < 256; a++) begin
                    wr_en = 1'b1; wr_addr = 8'(a); wr_data = exp_pix(K_PLAIN, a, 8'd0);
                    @(negedge clk);
                end
                wr_en = 1'b0; swap_req = 1'b1;
                @(negedge clk);
                swap_req = 1'b0;
                chk("f1_pend_set", 32'(swap_pending), 32'd1);
            end
        join
        verify("f1", K_A, 1, 3, 1);

        // ---------------- frame 2 shows data = addr ------------------------
        collect();
        verify("f2", K_PLAIN, 2, 1, 0);

        // ---------------- frame 3: write B to bank 1, swap on frame-start --
        wait_vs_rise(w);
        chk("f3_wait", 32'(w), 32'd1);
        for (int k = 1; k <= 479; k++) begin
            @(negedge clk);
            if (k <= 256) begin
                wr_en = 1'b1; wr_addr = 8'(k - 1); wr_data = exp_pix(K_B, k - 1, 8'd0);
            end else begin
                wr_en = 1'b0;
            end
            if (k == 477) chk("f3_pend_before", 32'(swap_pending), 32'd0);
            swap_req = (k == 478);
            if (k == 479) chk("f3_pend_at_start", 32'(swap_pending), 32'd1);
        end
        swap_req = 1'b0;

        // frame 4 still shows bank 0; swap lands at frame 5
        collect();
        verify("f4", K_PLAIN, 4, 1, 1);
        collect();
        verify("f5", K_B, 5, 1, 0);

        // ---------------- frame 6: enable dropped at line 5 ----------------
        fork
            collect();
            begin
                repeat (121) @(negedge clk);
                enable = 1'b0;
            end
        join
        verify("f6", K_B, 6, 1, 0);
        quiet = 0;
        repeat (60) begin
            @(negedge clk);
            if (vga_vs || vga_hs || vga_de || (vga_data != 24'd0)) quiet++;
        end
        chk("idle_outputs_active", 32'(quiet), 32'd0);
        chk("idle_fc_hold", 32'(frame_cnt), 32'd6);

        // ---------------- frame 7: restart, pattern requested --------------
        pat_en = 1'b1;
        enable = 1'b1;
        collect();
`ifdef TEST_PATTERN_EN
        verify("f7", K_PAT, 7, 3, 0);
        chk("f7_r3c5", 32'(pix[53]), 32'h050307);
`else
        verify("f7", K_B, 7, 3, 0);
        chk("f7_r3c5", 32'(pix[53]), 32'(exp_pix(K_B, 53, 8'd0)));
`endif

        // ---------------- frame 8: async reset at line 10, h=12 ------------
        wait_vs_rise(w);
        chk("f8_wait", 32'(w), 32'd1);
        repeat (5) @(negedge clk);
        swap_req = 1'b1;
        @(negedge clk);
        swap_req = 1'b0;
        pat_en   = 1'b0;
        repeat (246) @(negedge clk);
        chk("f8_pre_pend", 32'(swap_pending), 32'd1);
        chk("f8_pre_vs",   32'(vga_vs),       32'd1);
        chk("f8_pre_de",   32'(vga_de),       32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_vs",   32'(vga_vs),       32'd0);
        chk("arst_hs",   32'(vga_hs),       32'd0);
        chk("arst_de",   32'(vga_de),       32'd0);
        chk("arst_data", 32'(vga_data),     32'd0);
        chk("arst_fc",   32'(frame_cnt),    32'd0);
        chk("arst_pend", 32'(swap_pending), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // frame 9: clean frame from line 0, front bank back to 0
        collect();
        verify("f9", K_PLAIN, 1, 3, 0);

        // ---------------- frame_cnt wrap on the small instance -------------
        @(negedge clk);
        s_rst_n = 1'b1;
        @(negedge clk);
        s_en = 1'b1;
        repeat (2) @(negedge clk);
        chk("wrap_fc1", 32'(s_fcnt), 32'd1);
        s_vs_n = 0; s_hs_n = 0; s_de_n = 0;
        repeat (8 * 254) begin
            @(negedge clk);
            if (s_vs) s_vs_n++;
            if (s_hs) s_hs_n++;
            if (s_de) s_de_n++;
        end
        chk("wrap_fc255", 32'(s_fcnt), 32'd255);
        chk("small_vs_n", 32'(s_vs_n), 32'd1016);
        chk("small_hs_n", 32'(s_hs_n), 32'd508);
        chk("small_de_n", 32'(s_de_n), 32'd508);
        repeat (8) @(negedge clk);
        chk("wrap_fc0",   32'(s_fcnt), 32'd0);
        chk("small_pend", 32'(s_pend), 32'd0);
        $display("wrap: frame_cnt after 256 frames = %0d", s_fcnt);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/frames_in.md
Name: frames_in

Overview:
- Synthesizable video frame source; the transmit-side counterpart of the simulation frame logger.
- Generates vga_vs/vga_hs/vga_de timing plus 24-bit RGB pixels from a double-buffered on-chip frame store that a host fills through a write port.
- Drives the neuro skin pipeline input and the frame logger in closed-loop benches.

Parameters:
H_ACT, 16, active pixels per line
V_ACT, 16, active lines per frame
H_BLANK, 8, blank clocks per line, placed before the active pixels; must be >= 2
V_BLANK, 4, blank lines per frame, placed after the active lines; must be >= 1
HS_W, 2, hsync width in clocks; must be < H_BLANK

Ports:
vga_clk  in  1  pixel clock
vga_rst_n  in  1  asynchronous active-low reset
enable  in  1  run request, level
wr_en  in  1  frame store write strobe
wr_addr  in  clog2(H_ACT*V_ACT)  pixel address, row*H_ACT+col
wr_data  in  24  RGB pixel {R[23:16],G[15:8],B[7:0]}
swap_req  in  1  pulse: back bank complete, swap at next frame start
pat_en  in  1  test pattern select (see Optional Feature)
swap_pending  out  1  swap requested, not yet applied
vga_vs  out  1  high during active lines
vga_hs  out  1  line sync
vga_de  out  1  pixel valid
vga_data  out  24  pixel RGB
frame_cnt  out  8  frames started, mod 256

Behaviour:
- Reset: all outputs 0; state IDLE; h=v=0; front bank 0.
- Reset is asynchronous; assertion mid-frame zeroes all outputs immediately.
- Line length: H_BLANK+H_ACT clocks. Frame length: V_ACT+V_BLANK lines. Defaults give 24 clocks/line and 480 clocks/frame.
- FSM:
  - IDLE: counters held at 0, all timing outputs 0. enable=1 -> RUN, with the frame-start event in the next cycle.
  - RUN: h increments and wraps to 0 while v increments. At the last clock of the frame (h and v both at maximum): enable=0 -> IDLE; otherwise wrap to the next frame.
  - enable deasserted mid-frame: the current frame completes; it is never truncated.
- Timing, defined on counter position:
  - vs=1 for lines 0..V_ACT-1.
  - hs=1 for h<HS_W on every line.
  - de=1 when v<V_ACT and h>=H_BLANK.
- Because H_BLANK >= 1, a vs rising edge always precedes the first de of a frame by at least H_BLANK clocks.
- Alignment:
  - The frame store is synchronous-read.
  - vs, hs, de and vga_data are all registered and aligned, with a fixed 2-clock latency from counter position.
  - vga_data is 0 whenever de=0.
- Frame store:
  - Two banks of H_ACT*V_ACT x 24 bits.
  - Writes always target the back bank (not front). The back bank is evaluated with the pre-swap value in the swap cycle.
  - Reads use address (v*H_ACT + h-H_BLANK) in the front bank.
  - No write/read collision is possible.
- Swap:
  - swap_req sets swap_pending, which is sticky; further requests while pending have no effect.
  - At each frame-start event (h=v=0 in RUN, including the first frame after IDLE), if swap_pending=1: front toggles and swap_pending clears.
  - swap_req coincident with a frame-start event is recorded, not applied, and takes effect at the following frame start.
- frame_cnt increments at each frame-start event and wraps 255->0.

Optional Feature:
- Macro TEST_PATTERN_EN.
- When defined:
  - pat_en is sampled at each frame-start event and held for the frame.
  - If the sampled value is 1, vga_data = {col[7:0], row[7:0], frame_cnt}, using the frame_cnt value of that frame. The frame store is not read.
- When undefined: pat_en is ignored, no pattern logic is synthesized, and vga_data always comes from the frame store.
- Port list is identical in both builds.

Test Plan:
- Reset, enable=1, defaults -> vs high 384 clocks / low 96 per 480-clock frame; 256 de pulses per frame, 16 per line; first de 8 clocks after vs rise (hs rise to de rise = 8); frame_cnt=1 after first frame start.
- Write bank 1 with data=addr, swap_req -> swap_pending=1 until the next frame start, then 0. That frame shows pixel 0x000000..0x0000FF in raster order. Previous frame unaffected.
- swap_req on the exact frame-start cycle -> swap_pending=1 through that frame; swap applied one frame later.
- enable dropped at line 5 -> frame finishes all 20 lines, then all outputs 0, state IDLE. enable=1 again -> new frame starts with vs rising, frame_cnt+1.
- vga_rst_n low at line 10, h=12 -> outputs 0 asynchronously, frame_cnt=0, swap_pending=0. Release + enable -> clean frame from line 0.
- TEST_PATTERN_EN, pat_en=1 -> pixel (row 3, col 5) of frame with frame_cnt=7 is 0x050307. Run 256 frames -> frame_cnt wraps to 0. Without macro, same stimulus -> store data.
